bus_initiator_8088: RTL and testbench

BUS_INITIATOR_8088 -- requirements
Module: bus_initiator_8088

---
 rtl/bus_initiator_8088_if.sv | 28 ++
 rtl/bus_initiator_8088.sv | 98 +++++++++
 tb/tb_bus_initiator_8088.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_initiator_8088_if.sv
// Request/response handshake and 8088-style bus strobes for bus_initiator_8088.
// The bidirectional data bus is kept as a plain inout port on the initiator.
interface bus_initiator_8088_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  ReqValid;
  logic                  ReqReady;
  logic                  ReqWrite;
  logic [ADDR_WIDTH-1:0] ReqAddr;
  logic [DATA_WIDTH-1:0] ReqWData;
  logic                  RespValid;
  logic [DATA_WIDTH-1:0] RespRData;
  logic                  CS;
  logic                  OE;
  logic                  WR;
  logic [ADDR_WIDTH-1:0] Address;

  modport master (
    input  ReqValid, ReqWrite, ReqAddr, ReqWData,
    output ReqReady, RespValid, RespRData, CS, OE, WR, Address
  );

  modport slave (
    output ReqValid, ReqWrite, ReqAddr, ReqWData,
    input  ReqReady, RespValid, RespRData, CS, OE, WR, Address
  );
endinterface

// File: rtl/bus_initiator_8088.sv
// Single-transaction 8088-style bus initiator: IDLE -> T1 -> T2 -> T3 (turnaround).
// All bus outputs are decoded from the registered state and latched request fields.
module bus_initiator_8088 #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RESET,
  bus_initiator_8088_if.master  bus,
  // Tristate data bus stays a direct port so it resolves against the responder.
  inout  wire  [DATA_WIDTH-1:0] Data
);

  typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;

  state_e                state_q, state_d;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic req_ready;
  logic accept;
  logic cs;
  logic oe_n;
  logic wr_n;
  logic drive;
  logic resp_valid;

  assign accept = bus.ReqValid && req_ready;

  // State register and request/response latches; reset wins over acceptance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        write_q <= bus.ReqWrite;
        addr_q  <= bus.ReqAddr;
        wdata_q <= bus.ReqWData;
      end
      // Read data is captured at the edge that ends T2.
      if (state_q == StT2 && !write_q) begin
        rdata_q <= Data;
      end
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    cs         = 1'b0;
    oe_n       = 1'b1;
    wr_n       = 1'b1;
    drive      = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (bus.ReqValid) state_d = StT1;
      end
      StT1: begin
        cs      = 1'b1;
        oe_n    = write_q;
        wr_n    = !write_q;
        drive   = write_q;
        state_d = StT2;
      end
      StT2: begin
        cs      = 1'b1;
        drive   = write_q;
        state_d = StT3;
      end
      StT3: begin
        // CS drops here so back-to-back transactions always see a CS=0 gap.
        req_ready  = 1'b1;
        resp_valid = 1'b1;
        state_d    = bus.ReqValid ? StT1 : StIdle;
      end
    endcase
  end

  assign bus.ReqReady  = req_ready;
  assign bus.RespValid = resp_valid;
  assign bus.RespRData = rdata_q;
  assign bus.CS        = cs;
  assign bus.OE        = oe_n;
  assign bus.WR        = wr_n;
  assign bus.Address   = addr_q;
  assign Data          = drive ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_bus_initiator_8088.sv
// Randomized bench for bus_initiator_8088 against a cycle-schedule transaction model
// and a simple bus-level memory responder.
module tb_bus_initiator_8088;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  bus_initiator_8088_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  // Pulled high so an undriven bus reads as all ones.
  tri1 [DW-1:0] data_bus;

  bus_initiator_8088 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bif.master),
    .Data  (data_bus)
  );

  // ---------------- memory responder (the bus target) ----------------
  logic [7:0] tmem     [256];
  logic [7:0] init_val [256];
  logic       mem_load;
  logic       rd_phase;
  logic       wr_pend;
  logic [7:0] mem_out;
  logic       mem_drive;

  assign mem_drive = rd_phase && bif.CS;
  assign data_bus  = mem_drive ? mem_out : 8'bz;

  // Read: address seen with OE low, data driven in the following CS cycle.
  // Write: captured with WR low, committed only if CS is still high next cycle.
  always @(posedge CLK) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) tmem[i] <= init_val[i];
      rd_phase <= 1'b0;
      wr_pend  <= 1'b0;
      mem_out  <= 8'h00;
    end else begin
      rd_phase <= bif.CS && !bif.OE;
      if (bif.CS && !bif.OE) mem_out <= tmem[bif.Address[7:0]];
      if (bif.CS && !bif.WR) begin
        wr_pend <= 1'b1;
      end else begin
        if (bif.CS && wr_pend) tmem[bif.Address[7:0]] <= data_bus;
        wr_pend <= 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  // age = cycles since the current transaction was accepted (0 = none in flight).
  int         age;
  logic       cw;
  logic [19:0] ca;
  logic [7:0] cd;
  logic [19:0] addr_m;
  logic [7:0] rdata_m;
  logic [7:0] ref_mem [256];
  logic [19:0] pool [16];

  int n_checks;
  int n_errors;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic busy;
    busy = (age == 1) || (age == 2);
    check_eq("ready",   32'(bif.ReqReady),  32'((age == 0) || (age == 3)));
    check_eq("cs",      32'(bif.CS),        32'(busy));
    check_eq("oe_n",    32'(bif.OE),        32'(!(age == 1 && !cw)));
    check_eq("wr_n",    32'(bif.WR),        32'(!(age == 1 && cw)));
    check_eq("resp",    32'(bif.RespValid), 32'(age == 3));
    check_eq("address", 32'(bif.Address),   32'(addr_m));
    check_eq("rdata",   32'(bif.RespRData), 32'(rdata_m));
    if (busy && cw) check_eq("data_wr", 32'(data_bus), 32'(cd));
    else if (!(age == 2 && !cw)) check_eq("data_z", 32'(data_bus), 32'hFF);
  endtask

  // Advance one clock: apply the model to the inputs present at the edge, then check.
  task automatic step();
    logic        v, w, r, rdy;
    logic [19:0] a;
    logic [7:0]  d;
    v   = bif.ReqValid;
    w   = bif.ReqWrite;
    a   = bif.ReqAddr;
    d   = bif.ReqWData;
    r   = RESET;
    rdy = (age == 0) || (age == 3);
    @(posedge CLK);
    if (r) begin
      age     = 0;
      addr_m  = '0;
      rdata_m = '0;
    end else begin
      if (age == 2) begin
        if (cw) ref_mem[ca[7:0]] = cd;
        else    rdata_m = ref_mem[ca[7:0]];
      end
      if (v && rdy) begin
        age    = 1;
        cw     = w;
        ca     = a;
        cd     = d;
        addr_m = a;
      end else if (age == 1 || age == 2) begin
        age++;
      end else begin
        age = 0;
      end
    end
    #2;
    check_outputs();
  endtask

  task automatic rand_inputs();
    bif.ReqValid = ($urandom_range(0, 2) != 0);
    bif.ReqWrite = 1'($urandom_range(0, 1));
    bif.ReqAddr  = pool[$urandom_range(0, 15)];
    bif.ReqWData = 8'($urandom_range(0, 254));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    age      = 0;
    cw       = 1'b0;
    ca       = '0;
    cd       = '0;
    addr_m   = '0;
    rdata_m  = '0;
    pool[0]  = 20'h12345;
    pool[1]  = 20'h00010;
    for (int i = 2; i < 16; i++) pool[i] = {12'($urandom_range(0, 4095)), 4'(i - 2), 4'h3};
    for (int i = 0; i < 256; i++) init_val[i] = 8'($urandom_range(0, 255));
    init_val[8'h45] = 8'h3C;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val[i];

    bif.ReqValid = 1'b0;
    bif.ReqWrite = 1'b0;
    bif.ReqAddr  = '0;
    bif.ReqWData = '0;
    mem_load     = 1'b1;
    RESET        = 1'b1;
    step();
    step();
    mem_load = 1'b0;
    RESET    = 1'b0;
    step();

    // Directed read of 0x12345.
    bif.ReqValid = 1'b1;
    bif.ReqWrite = 1'b0;
    bif.ReqAddr  = 20'h12345;
    step();
    bif.ReqValid = 1'b0;
    step();
    step();
    check_eq("read_3c", 32'(bif.RespRData), 32'h3C);
    step();

    // Directed write 0xA5 to 0x00010, inputs changed right after acceptance.
    bif.ReqValid = 1'b1;
    bif.ReqWrite = 1'b1;
    bif.ReqAddr  = 20'h00010;
    bif.ReqWData = 8'hA5;
    step();
    bif.ReqValid = 1'b0;
    bif.ReqAddr  = 20'h54321;
    bif.ReqWData = 8'h5A;
    step();
    step();
    step();
    bif.ReqValid = 1'b1;
    bif.ReqWrite = 1'b0;
    bif.ReqAddr  = 20'h00010;
    step();
    bif.ReqValid = 1'b0;
    step();
    step();
    check_eq("readback_a5", 32'(bif.RespRData), 32'hA5);
    step();

    // Back-to-back alternating write/read with ReqValid held high.
    bif.ReqValid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bif.ReqWrite = ((k % 2) == 0);
      bif.ReqAddr  = pool[2 + k];
      bif.ReqWData = 8'($urandom_range(0, 254));
      step();
      check_eq("b2b_t1_cs", 32'(bif.CS), 32'h1);
      if (k == 3) bif.ReqValid = 1'b0;
      bif.ReqAddr  = pool[$urandom_range(0, 15)];
      bif.ReqWData = 8'($urandom_range(0, 254));
      step();
      step();
      check_eq("b2b_t3_cs", 32'(bif.CS), 32'h0);
    end
    step();

    // Reset at the edge ending T1 of a write.
    bif.ReqValid = 1'b1;
    bif.ReqWrite = 1'b1;
    bif.ReqAddr  = pool[7];
    bif.ReqWData = ~ref_mem[pool[7][7:0]] & 8'hFE;
    step();
    bif.ReqValid = 1'b0;
    RESET        = 1'b1;
    step();
    RESET = 1'b0;
    step();
    step();

    // Randomized traffic with occasional resets.
    repeat (400) begin
      rand_inputs();
      RESET = ($urandom_range(0, 49) == 0);
      step();
    end
    RESET        = 1'b0;
    bif.ReqValid = 1'b0;
    repeat (4) step();

    for (int i = 0; i < 256; i++) check_eq("mem", 32'(tmem[i]), 32'(ref_mem[i]));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
